// File: rtl/lmsm_priority_encoder.sv
// Load/store-multiple register-list scanner: presents the lowest remaining set bit of a captured
// mask each cycle, consumes one bit per 'next', and pulses 'done' once the list is exhausted.
module lmsm_priority_encoder (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] mask_in,
   input  logic       next,
   output logic [2:0] index,
   output logic [7:0] sel_n,
   output logic       valid,
   output logic       done,
   output logic [3:0] count,
   output logic [7:0] mask_rem
);

   typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

   state_e     state_q, state_d;
   logic [7:0] mask_q, mask_d;
   logic [3:0] count_q, count_d;
   logic       valid_q, valid_d;
   logic       done_q, done_d;
   logic [2:0] low_idx;
   logic [7:0] mask_cleared;

   function automatic logic [2:0] lowest_index(input logic [7:0] m);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   assign low_idx      = lowest_index(mask_q);
   // Clearing the lowest set bit is the same as dropping bit low_idx.
   assign mask_cleared = mask_q & (mask_q - 8'd1);

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      count_d = count_q;
      valid_d = valid_q;
      done_d  = done_q;
      if (load) begin
         mask_d  = mask_in;
         count_d = 4'd0;
         if (mask_in != 8'h00) begin
            state_d = StActive;
            valid_d = 1'b1;
            done_d  = 1'b0;
         end else begin
            state_d = StDone;
            valid_d = 1'b0;
            done_d  = 1'b1;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               valid_d = 1'b0;
               done_d  = 1'b0;
            end
            StActive: begin
               if (next) begin
                  mask_d = mask_cleared;
                  if (count_q != 4'd8) count_d = count_q + 4'd1;
                  if (mask_cleared == 8'h00) begin
                     state_d = StDone;
                     valid_d = 1'b0;
                     done_d  = 1'b1;
                  end
               end
            end
            StDone: begin
               state_d = StIdle;
               valid_d = 1'b0;
               done_d  = 1'b0;
            end
            default: begin
               state_d = StIdle;
               valid_d = 1'b0;
               done_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         mask_q  <= 8'h00;
         count_q <= 4'd0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         count_q <= count_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign valid    = valid_q;
   assign done     = done_q;
   assign count    = count_q;
   assign mask_rem = mask_q;
   assign index    = valid_q ? low_idx : 3'd0;
   assign sel_n    = valid_q ? ~(8'b1 << low_idx) : 8'hFF;

endmodule

// File: tb/tb_lmsm_priority_encoder.sv
// Bench for lmsm_priority_encoder: directed vector table, hand-written corner sequences and a
// randomized run compared against a behavioural scan model.
module tb_lmsm_priority_encoder;

   logic       clk = 1'b0;
   logic       reset;
   logic       load;
   logic [7:0] mask_in;
   logic       next;
   logic [2:0] index;
   logic [7:0] sel_n;
   logic       valid;
   logic       done;
   logic [3:0] count;
   logic [7:0] mask_rem;

   int n_cmp = 0;
   int n_bad = 0;

   lmsm_priority_encoder dut (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .mask_in  (mask_in),
      .next     (next),
      .index    (index),
      .sel_n    (sel_n),
      .valid    (valid),
      .done     (done),
      .count    (count),
      .mask_rem (mask_rem)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       ld;
      bit [7:0] msk;
      bit       nx;
      bit [2:0] e_idx;
      bit [7:0] e_sel;
      bit       e_valid;
      bit       e_done;
      bit [3:0] e_cnt;
      bit [7:0] e_rem;
   } vec_t;

   // Behavioural model: the list of registers still to transfer plus a scan phase.
   bit [7:0] m_rem;
   int       m_cnt;
   bit       m_scanning;
   bit       m_finished;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_outs(input string tag, input bit [2:0] e_idx, input bit [7:0] e_sel,
                             input bit e_valid, input bit e_done, input bit [3:0] e_cnt,
                             input bit [7:0] e_rem);
      cmp({tag, ".index"}, 32'(index), 32'(e_idx));
      cmp({tag, ".sel_n"}, 32'(sel_n), 32'(e_sel));
      cmp({tag, ".valid"}, 32'(valid), 32'(e_valid));
      cmp({tag, ".done"}, 32'(done), 32'(e_done));
      cmp({tag, ".count"}, 32'(count), 32'(e_cnt));
      cmp({tag, ".mask_rem"}, 32'(mask_rem), 32'(e_rem));
   endtask

   function automatic int first_set(input bit [7:0] m);
      for (int i = 0; i < 8; i++) if (m[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      m_rem = 8'h00;
      m_cnt = 0;
      m_scanning = 1'b0;
      m_finished = 1'b0;
   endtask

   task automatic model_step(input bit ld, input bit [7:0] msk, input bit nx);
      if (ld) begin
         m_rem = msk;
         m_cnt = 0;
         m_scanning = (msk != 0);
         m_finished = (msk == 0);
      end else if (m_scanning) begin
         if (nx) begin
            m_rem[first_set(m_rem)] = 1'b0;
            m_cnt++;
            if (m_rem == 0) begin
               m_scanning = 1'b0;
               m_finished = 1'b1;
            end
         end
      end else begin
         m_finished = 1'b0;
      end
   endtask

   task automatic model_check(input string tag);
      bit [7:0] sel;
      int       idx;
      sel = 8'hFF;
      idx = 0;
      if (m_scanning) begin
         idx = first_set(m_rem);
         sel[idx] = 1'b0;
      end
      check_outs(tag, 3'(idx), sel, m_scanning, m_finished, 4'(m_cnt), m_rem);
   endtask

   // Drive inputs just after an edge, then sample 1 time unit after the following edge.
   task automatic cycle(input bit ld, input bit [7:0] msk, input bit nx);
      load = ld;
      mask_in = msk;
      next = nx;
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[$];

   initial begin
      reset = 1'b1;
      load = 1'b0;
      mask_in = 8'h00;
      next = 1'b0;
      #12;
      check_outs("reset", 3'd0, 8'hFF, 1'b0, 1'b0, 4'd0, 8'h00);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // ld msk nx | idx sel valid done cnt rem
      vecs.push_back('{1, 8'hA4, 0, 3'd2, 8'hFB, 1, 0, 4'd0, 8'hA4});
      vecs.push_back('{0, 8'h00, 1, 3'd5, 8'hDF, 1, 0, 4'd1, 8'hA0});
      vecs.push_back('{0, 8'h11, 1, 3'd7, 8'h7F, 1, 0, 4'd2, 8'h80});
      vecs.push_back('{0, 8'h00, 1, 3'd0, 8'hFF, 0, 1, 4'd3, 8'h00});
      vecs.push_back('{0, 8'h00, 0, 3'd0, 8'hFF, 0, 0, 4'd3, 8'h00});
      vecs.push_back('{0, 8'hFF, 1, 3'd0, 8'hFF, 0, 0, 4'd3, 8'h00});
      vecs.push_back('{1, 8'h00, 0, 3'd0, 8'hFF, 0, 1, 4'd0, 8'h00});
      vecs.push_back('{0, 8'h00, 1, 3'd0, 8'hFF, 0, 0, 4'd0, 8'h00});
      vecs.push_back('{1, 8'h0F, 0, 3'd0, 8'hFE, 1, 0, 4'd0, 8'h0F});
      vecs.push_back('{0, 8'h00, 1, 3'd1, 8'hFD, 1, 0, 4'd1, 8'h0E});
      vecs.push_back('{0, 8'h00, 1, 3'd2, 8'hFB, 1, 0, 4'd2, 8'h0C});
      vecs.push_back('{1, 8'h80, 1, 3'd7, 8'h7F, 1, 0, 4'd0, 8'h80});
      vecs.push_back('{0, 8'h00, 1, 3'd0, 8'hFF, 0, 1, 4'd1, 8'h00});
      vecs.push_back('{0, 8'h00, 1, 3'd0, 8'hFF, 0, 0, 4'd1, 8'h00});
      vecs.push_back('{1, 8'hFF, 0, 3'd0, 8'hFE, 1, 0, 4'd0, 8'hFF});
      foreach (vecs[i]) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         cycle(vecs[i].ld, vecs[i].msk, vecs[i].nx);
         check_outs(tag, vecs[i].e_idx, vecs[i].e_sel, vecs[i].e_valid, vecs[i].e_done,
                    vecs[i].e_cnt, vecs[i].e_rem);
      end

      // Full mask with next held: indices 1..7 follow on consecutive cycles, then done.
      for (int k = 1; k <= 8; k++) begin
         bit [7:0] e_rem;
         bit [7:0] e_sel;
         e_rem = 8'hFF << k;
         e_sel = 8'hFF;
         if (k < 8) e_sel[k] = 1'b0;
         cycle(1'b0, 8'h00, 1'b1);
         check_outs($sformatf("ff_run%0d", k), (k < 8) ? 3'(k) : 3'd0, e_sel, k < 8, k == 8,
                    4'(k), e_rem);
      end
      cycle(1'b0, 8'h00, 1'b1);
      check_outs("ff_idle", 3'd0, 8'hFF, 1'b0, 1'b0, 4'd8, 8'h00);

      // Asynchronous reset mid-scan, between edges.
      cycle(1'b1, 8'h30, 1'b0);
      check_outs("pre_rst", 3'd4, 8'hEF, 1'b1, 1'b0, 4'd0, 8'h30);
      load = 1'b0;
      next = 1'b1;
      #3;
      reset = 1'b1;
      #1;
      check_outs("async_rst", 3'd0, 8'hFF, 1'b0, 1'b0, 4'd0, 8'h00);
      @(posedge clk);
      #3;
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, 8'h00, 1'b1);
         check_outs($sformatf("post_rst%0d", k), 3'd0, 8'hFF, 1'b0, 1'b0, 4'd0, 8'h00);
      end

      // Randomized traffic against the model, starting from reset.
      model_reset();
      for (int k = 0; k < 600; k++) begin
         bit       ld;
         bit [7:0] msk;
         bit       nx;
         ld  = ($urandom_range(0, 5) == 0);
         msk = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         nx  = ($urandom_range(0, 3) != 0);
         model_step(ld, msk, nx);
         cycle(ld, msk, nx);
         model_check($sformatf("rnd%0d", k));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
